fifo_rd_stream: RTL

//  Read-side consumer for async_fifo, sitting in the read clock domain.

---
 rtl/fifo_rd_stream_pkg.sv | 10 +
 rtl/fifo_rd_stream_if.sv | 12 +
 rtl/fifo_skid_buf2.sv | 27 ++
 rtl/fifo_rd_stream.sv | 39 +++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: defaults shared with async_fifo plus occupancy type and arithmetic for the read-side skid buffer
package fifo_rd_stream_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 16;
  typedef logic [1:0] occ_t;
  localparam occ_t OCC_MAX = 2'd2;
  function automatic logic [2:0] occ_after(occ_t occ, logic push, logic pop);
    return {1'b0, occ} + {2'b0, push} - {2'b0, pop};
  endfunction
endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port and valid/ready stream; master = fifo_rd_stream, slave = FIFO and downstream side
interface fifo_rd_stream_if import fifo_rd_stream_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic fifo_rd_err;
  logic fifo_rd_en;
  logic m_valid;
  logic [WIDTH-1:0] m_data;
  logic m_ready;
  modport master (input fifo_empty, fifo_rdata, fifo_rd_err, m_ready, output fifo_rd_en, m_valid, m_data);
  modport slave (output fifo_empty, fifo_rdata, fifo_rd_err, m_ready, input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_skid_buf2.sv
// fifo_skid_buf2: 2-entry register FIFO; ports clk_i/rst_n_i (async low), push_i/data_i in, pop_i out, occ_o count, head_o oldest word
module fifo_skid_buf2 import fifo_rd_stream_pkg::*; #(parameter int WIDTH = WIDTH_DEF) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output occ_t             occ_o,
  output logic [WIDTH-1:0] head_o
);
  logic [WIDTH-1:0] d1;
  logic [2:0] occ_n;
  assign occ_n = occ_after(occ_o, push_i, pop_i);
  // head_o is entry 0, d1 is entry 1; a pop shifts d1 forward unless the incoming word becomes the head
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      occ_o <= '0;
      head_o <= '0;
      d1 <= '0;
    end else begin
      occ_o <= occ_n[1:0];
      head_o <= pop_i ? (occ_o == 2'd1 ? (push_i ? data_i : head_o) : d1) : (push_i && occ_o == 2'd0 ? data_i : head_o);
      d1 <= push_i && ((occ_o == 2'd1 && !pop_i) || (occ_o == 2'd2 && pop_i)) ? data_i : d1;
    end
  a_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_n_i) occ_n <= {1'b0, OCC_MAX});
  a_no_udf: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(pop_i && occ_o == 2'd0));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async_fifo read-side consumer; ports clk_i, rst_n_i (async low), enable_i, bus (FIFO read + stream), rd_cnt_o delivered words, err_o sticky read error
module fifo_rd_stream import fifo_rd_stream_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  fifo_rd_stream_if.master     bus,
  output logic [CNT_WIDTH-1:0] rd_cnt_o,
  output logic                 err_o
);
  occ_t occ;
  logic infl;
  logic pop;
  assign pop = bus.m_valid & bus.m_ready;
  assign bus.m_valid = occ != 2'd0;
  // a new read is allowed only if the word it returns next cycle is guaranteed a free slot
  assign bus.fifo_rd_en = rst_n_i & enable_i & ~bus.fifo_empty & (occ_after(occ, infl, pop) <= 3'd1);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      infl <= 1'b0;
      rd_cnt_o <= '0;
      err_o <= 1'b0;
    end else begin
      infl <= bus.fifo_rd_en;
      rd_cnt_o <= rd_cnt_o + CNT_WIDTH'(pop);
      err_o <= err_o | bus.fifo_rd_err;
    end
  fifo_skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (infl),
    .pop_i  (pop),
    .data_i (bus.fifo_rdata),
    .occ_o  (occ),
    .head_o (bus.m_data)
  );
endmodule
